// File: rtl/out_ddr_pkg.sv
// Shared mode encoding and sizing helper for the DDR output bus.
package out_ddr_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_NORMAL = 2'd0;
  localparam mode_t MODE_IDLE   = 2'd1;
  localparam mode_t MODE_TRAIN  = 2'd2;

  // Bits needed to count 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/out_ddr_flop.sv
// Single-bit DDR output register: d1 on the high phase, d2 on the low phase.
module out_ddr_flop (
  input  logic clk,
  input  logic rst,
  input  logic d1,
  input  logic d2,
  output logic q
);

  logic q_rise;
  logic q_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_rise <= 1'b0;
      q_fall <= 1'b0;
    end else begin
      q_rise <= d1;
      q_fall <= d2;
    end
  end

  // Behavioural stand-in for the IOB ODDR primitive (same-edge capture).
  assign q = clk ? q_rise : q_fall;

endmodule

// File: rtl/out_ddr_bus.sv
// Multi-bit DDR output port: small word-pair FIFO, idle/training patterns,
// sticky underrun detection, one DDR register per output bit.
module out_ddr_bus
  import out_ddr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] IDLE_RISE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] IDLE_FALL = {WIDTH{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  mode_t                         mode,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_rise,
  input  logic [WIDTH-1:0]              in_fall,
  input  logic                          underrun_clr,
  output logic                          underrun,
  output logic [level_width(DEPTH)-1:0] level,
  output logic [WIDTH-1:0]              q
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem_rise [DEPTH];
  logic [WIDTH-1:0] mem_fall [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             active;
  logic [WIDTH-1:0] stage_rise;
  logic [WIDTH-1:0] stage_fall;
  logic [WIDTH-1:0] next_rise;
  logic [WIDTH-1:0] next_fall;
  logic             do_push;
  logic             do_pop;
  logic             underrun_set;

  assign in_ready     = (level < LW'(DEPTH));
  assign do_push      = in_valid && in_ready && !flush;
  assign do_pop       = (mode == MODE_NORMAL) && (level != '0) && !flush;
  assign underrun_set = active && (mode == MODE_NORMAL) && (level == '0);

  always_comb begin
    next_rise = IDLE_RISE;
    next_fall = IDLE_FALL;
    if (!flush) begin
      case (mode)
        MODE_NORMAL: begin
          if (do_pop) begin
            next_rise = mem_rise[rd_ptr];
            next_fall = mem_fall[rd_ptr];
          end
        end
        MODE_TRAIN: begin
          next_rise = '1;
          next_fall = '0;
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by level and the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_rise[wr_ptr] <= in_rise;
      mem_fall[wr_ptr] <= in_fall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      active     <= 1'b0;
      underrun   <= 1'b0;
      stage_rise <= IDLE_RISE;
      stage_fall <= IDLE_FALL;
    end else begin
      stage_rise <= next_rise;
      stage_fall <= next_fall;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({do_push, do_pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: ;
        endcase
      end

      if (flush || (mode != MODE_NORMAL)) active <= 1'b0;
      else if (do_pop)                    active <= 1'b1;

      // A new starvation outranks a clear arriving in the same cycle.
      if (underrun_set)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_oddr
    out_ddr_flop u_flop (
      .clk (clk),
      .rst (rst),
      .d1  (stage_rise[i]),
      .d2  (stage_fall[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_out_ddr_bus.sv
// Directed bench for out_ddr_bus: streaming, fill, training, underrun race,
// flush-with-push and mid-stream reset, with hand-computed expectations.
module tb_out_ddr_bus;
  import out_ddr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  mode_t      mode;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_rise;
  logic [7:0] in_fall;
  logic       underrun_clr;
  logic       underrun;
  logic [2:0] level;
  logic [7:0] q;

  int total = 0;
  int bad   = 0;

  out_ddr_bus #(
    .WIDTH     (8),
    .DEPTH     (4),
    .IDLE_RISE (8'h3C),
    .IDLE_FALL (8'hC3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rise      (in_rise),
    .in_fall      (in_fall),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .level        (level),
    .q            (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (clk high).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after step(): checks the high phase, then the low phase.
  task automatic chk_q(input logic [7:0] exp_r, input logic [7:0] exp_f, input string tag);
    chk({24'b0, q}, {24'b0, exp_r}, {tag, "_rise"});
    #5;
    chk({24'b0, q}, {24'b0, exp_f}, {tag, "_fall"});
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] f);
    in_valid = 1'b1;
    in_rise  = r;
    in_fall  = f;
  endtask

  initial begin
    rst = 1'b1; mode = MODE_NORMAL; flush = 1'b0; in_valid = 1'b0;
    in_rise = '0; in_fall = '0; underrun_clr = 1'b0;

    // Reset state
    step(); step();
    chk(level, 0, "rst_level");
    chk(in_ready, 1, "rst_ready");
    chk(underrun, 0, "rst_underrun");
    chk_q(8'h00, 8'h00, "rst_q");
    rst = 1'b0;
    step();
    chk_q(8'h3C, 8'hC3, "post_rst_idle");

    // Stream three pairs in NORMAL
    push(8'hA5, 8'h5A); step();
    chk(level, 1, "stream_level1");
    push(8'h01, 8'h80); step();
    chk(level, 1, "stream_level_pp");
    push(8'hFF, 8'h00); step();
    chk_q(8'hA5, 8'h5A, "stream_p0");
    in_valid = 1'b0;
    step();
    chk_q(8'h01, 8'h80, "stream_p1");
    chk(level, 0, "stream_empty");
    chk(underrun, 0, "stream_no_underrun_yet");
    step();
    chk_q(8'hFF, 8'h00, "stream_p2");
    chk(underrun, 1, "stream_underrun");
    step();
    chk_q(8'h3C, 8'hC3, "stream_idle");

    // Fill in IDLE mode
    mode = MODE_IDLE; underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk(underrun, 0, "fill_clr");
    push(8'h11, 8'hE1); step();
    push(8'h22, 8'hD2); step();
    push(8'h33, 8'hC3); step();
    chk(level, 3, "fill_level3");
    chk(in_ready, 1, "fill_ready3");
    push(8'h44, 8'hB4); step();
    chk(level, 4, "fill_level4");
    chk(in_ready, 0, "fill_full");
    push(8'h55, 8'hA5); step();
    chk(level, 4, "fill_ignore5");
    in_valid = 1'b0;
    chk_q(8'h3C, 8'hC3, "fill_idle_q");

    // Training with a full FIFO
    mode = MODE_TRAIN;
    step();
    chk_q(8'h3C, 8'hC3, "train_lag");
    step();
    chk_q(8'hFF, 8'h00, "train_a");
    step();
    chk_q(8'hFF, 8'h00, "train_b");
    chk(level, 4, "train_level");
    chk(underrun, 0, "train_underrun");

    // Drain the full FIFO in NORMAL
    mode = MODE_NORMAL;
    step();
    chk_q(8'hFF, 8'h00, "drain_train_tail");
    chk(level, 3, "drain_level3");
    chk(in_ready, 1, "drain_ready");
    step();
    chk_q(8'h11, 8'hE1, "drain_0");
    step();
    chk_q(8'h22, 8'hD2, "drain_1");
    step();
    chk_q(8'h33, 8'hC3, "drain_2");
    chk(level, 0, "drain_empty");
    step();
    chk_q(8'h44, 8'hB4, "drain_3");
    chk(underrun, 1, "drain_underrun");

    // Clear racing a new starvation: set wins
    underrun_clr = 1'b1;
    step();
    chk_q(8'h3C, 8'hC3, "drain_no_fifth");
    chk(underrun, 1, "race_set_wins");
    underrun_clr = 1'b0;
    push(8'h66, 8'h99); step();
    chk(level, 1, "race_fed");
    underrun_clr = 1'b1;
    push(8'h77, 8'h88); step();
    chk(underrun, 0, "race_clear_fed");
    underrun_clr = 1'b0; in_valid = 1'b0;
    step();
    chk_q(8'h66, 8'h99, "race_q0");
    step();
    chk_q(8'h77, 8'h88, "race_q1");
    chk(underrun, 1, "race_restarve");

    // Flush with a simultaneous push at level 3
    mode = MODE_IDLE;
    push(8'hA1, 8'h1A); step();
    push(8'hB2, 8'h2B); step();
    push(8'hC3, 8'h3C); step();
    chk(level, 3, "flush_pre_level");
    mode = MODE_NORMAL; flush = 1'b1;
    push(8'hD4, 8'h4D); step();
    flush = 1'b0; in_valid = 1'b0;
    chk(level, 0, "flush_level");
    step();
    chk_q(8'h3C, 8'hC3, "flush_q1");
    chk(level, 0, "flush_level_hold");
    step();
    chk_q(8'h3C, 8'hC3, "flush_q2");

    // Mid-stream reset
    push(8'h12, 8'h21); step();
    push(8'h34, 8'h43); step();
    push(8'h56, 8'h65); step();
    chk_q(8'h12, 8'h21, "mrst_stream");
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk_q(8'h00, 8'h00, "mrst_q");
    chk(level, 0, "mrst_level");
    chk(underrun, 0, "mrst_underrun");
    rst = 1'b0;
    step();
    chk_q(8'h3C, 8'hC3, "mrst_idle1");
    step();
    chk_q(8'h3C, 8'hC3, "mrst_idle2");
    chk(level, 0, "mrst_level_after");
    push(8'h9A, 8'hA9); step();
    in_valid = 1'b0;
    step();
    step();
    chk_q(8'h9A, 8'hA9, "mrst_new_pair");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/out_ddr_bus.md
# out_ddr_bus

Parametrised multi-bit DDR output port for the waveform generator's output path. A small FIFO accepts rise/fall word pairs under a valid/ready handshake. Each word pair drives one DDR output register per bit, so every word pair is one clock period on the pins. The block adds idle and training modes and underrun detection, which the single-bit DDR flop lacks.

## Interface
- WIDTH, 8: number of DDR output bits.
- DEPTH, 4: FIFO entries; must be a power of 2, ≥2.
- IDLE_RISE, {WIDTH{1'b0}}: word driven on the rising half when idle or starved.
- IDLE_FALL, {WIDTH{1'b0}}: word driven on the falling half when idle or starved.

Ports:
- clk  in  1  destination clock; also the DDR output clock.
- rst  in  1  reset, synchronous to clk, active-high.
- mode  in  2  output mode; encoding from the package; sampled every rising edge.
- flush  in  1  synchronous FIFO clear.
- in_valid  in  1  input word pair valid.
- in_ready  out  1  FIFO can accept a word pair.
- in_rise  in  WIDTH  data for the rising half.
- in_fall  in  WIDTH  data for the falling half.
- underrun_clr  in  1  clears the underrun flag.
- underrun  out  1  sticky starvation flag.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- q  out  WIDTH  DDR output to the IOBs.

## Operation
- Modes:
  - NORMAL=0: pop one entry per cycle while the FIFO is non-empty.
  - IDLE=1: no pop; drive IDLE_RISE/IDLE_FALL.
  - TRAIN=2: no pop; drive rise=all ones and fall=all zeros, giving a clock-like pattern on every bit.
  - 3: reserved; behaves as IDLE.
- Push: occurs when in_valid && in_ready. in_ready = (level < DEPTH), computed from registered state only. There is no push-through-pop when full.
- Pop: occurs when mode==NORMAL && level>0 && !flush. A pop loads the head entry into the stage registers (stage_rise/stage_fall).
  - In NORMAL with an empty FIFO, the stage loads the IDLE words.
  - In IDLE or TRAIN, the stage loads the corresponding pattern.
- Simultaneous push and pop: level is unchanged. Pointers wrap modulo DEPTH.
- flush: empties the FIFO (pointers and level to 0) and the stage loads the IDLE words. A push in the same cycle is discarded. flush takes priority over push and pop.
- Underrun tracking:
  - The active flag sets on the first pop in NORMAL mode.
  - The active flag clears on rst, on flush, or in any cycle mode≠NORMAL.
  - If active && mode==NORMAL && level==0 at an edge, underrun is set.
  - underrun_clr clears underrun. When a set and a clear occur in the same cycle, the set wins.
- DDR stage: one DDR output register per bit with D1=stage_rise[i], D2=stage_fall[i], SR=rst, and reset value 0.

## Timing
- Reset state, one edge after rst is asserted:
  - level=0, in_ready=1, underrun=0, active=0.
  - Stage holds the IDLE words.
  - q=0 while rst is high.
- Latency:
  - A word pair pushed at edge N into an empty FIFO in NORMAL mode is popped at N+1.
  - q shows in_rise during the high phase after N+2, then in_fall during the following low phase.
  - Mode changes take effect on q two edges after they are sampled.
- Back-to-back pushes into NORMAL mode produce a continuous stream with no idle gaps. Throughput is 1 word pair per cycle.
- FIFO full: in_ready=0 in the same cycle level reaches DEPTH. It returns to 1 the cycle after a pop.
- Reset mid-stream:
  - FIFO contents are discarded.
  - q is 0 from the first rst edge.
  - After release, q shows the IDLE words until the first pop.
- level updates one cycle after each push or pop.

## Structure
- Package out_ddr_pkg holds:
  - MODE_NORMAL, MODE_IDLE and MODE_TRAIN 2-bit constants;
  - the mode typedef;
  - a helper function for the level width.
- Sub-module: out_ddr_flop, the existing single-bit DDR output wrapper. It is instantiated WIDTH times in a generate loop with clk and rst shared.
- The FIFO is inline: a register array, pointers and a level counter. There is no separate FIFO module.

## Test plan
- Reset then stream: WIDTH=8. Push the pairs (0xA5,0x5A), (0x01,0x80) and (0xFF,0x00) in NORMAL mode. q must show A5,5A,01,80,FF,00 on alternating half-cycles starting 2 edges after the first push, then IDLE, and underrun must be 1.
- Fill: with mode=IDLE, push 4 pairs. in_ready must drop after the 4th and level=4. The 5th in_valid must be ignored. Switch to NORMAL; exactly 4 pairs must appear in order.
- Training: mode=TRAIN with a full FIFO. q must toggle FF/00 every half-cycle, and level must stay 4 with no underrun.
- Underrun clear race: assert underrun_clr in the same cycle a new starvation occurs. underrun must remain 1. A clear in a later cycle with the FIFO fed must give underrun=0.
- Flush with push: push and flush in the same cycle with level=3. The result must be level=0 and q=IDLE two edges later.
- Mid-stream reset: assert rst for 1 cycle while streaming. q must be 0 and level 0. After release, q must show IDLE until new pushes arrive.
